pipelined_cska: RTL and testbench
=================================

# pipelined_cska

Parametrised, pipelined carry-skip adder/subtractor with valid/ready flow control. It is the next-generation arithmetic unit for the datapath. It generalises the fixed 32-bit, 4-bit-block carry-skip adder in three ways: configurable width, block size and pipeline depth; an add/subtract mode; and signed-overflow reporting. Each pipeline stage resolves a contiguous slice of carry-skip blocks. Results stream out at one per cycle under backpressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of BLOCK.
- BLOCK, 4, bits per ripple block / skip group.
- STAGES, 2, pipeline register stages; must divide WIDTH/BLOCK; 1..WIDTH/BLOCK.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands on in1/in2/cin/sub are valid.
- in_ready  output  1  block accepts the operation this cycle.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-select (sub).
- sub  input  1  0 = A+B+cin, 1 = A+~B+(~cin), i.e. A−B−cin.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of MSB (sub: 1 = no borrow).
- ovf  output  1  signed overflow.

## Operation
- Accept on in_valid && in_ready. Stage 0 latches A, B' = sub ? ~in2 : in2, and c0 = cin ^ sub.
- Stage k (0..STAGES−1) processes blocks k·N..(k+1)·N−1, where N = WIDTH/(BLOCK·STAGES).
- Per block: ripple-carry sum bits from the block carry-in. Block carry-out = block carry-in if every propagate bit (A^B') in the block is 1 (skip); otherwise it is the ripple carry-out.
- Each stage register holds: the sum bits resolved so far, the unresolved operand bits, the carry into the next slice, the carry into the MSB (valid once the MSB block is done), and a valid bit. Unused low/high fields are don't-care but are reset to 0.
- cout = carry out of bit WIDTH−1; ovf = carry into bit WIDTH−1 XOR cout.
- Elastic pipeline: ready_k = !valid_k || ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0.
- A stage loads when its upstream is valid and ready_k is 1. It clears its valid when it empties without a refill.
- Simultaneous pop and push on a full stage is allowed. Operations stay in order; none is dropped or duplicated.
- Reset (async assert, sync-safe deassert via flops): all valid bits 0; all data registers 0.
  - During reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=0.
  - In-flight operations are discarded.

## Timing
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+STAGES−1, i.e. STAGES cycles, when the pipeline is not stalled.
- Throughput: one operation per cycle while out_ready=1.
- While out_valid && !out_ready, sum/cout/ovf/out_valid hold stable.
- With out_ready held low, the pipeline absorbs at most STAGES operations; in_ready=0 once all stages are valid.
- in_ready is combinational from out_ready and the stage valids. No combinational path exists from in1/in2/in_valid to any output.
- First cycle after rst_n rises: in_ready=1, out_valid=0.

## Test plan
All scenarios use WIDTH=32, BLOCK=4, STAGES=2.
- Reset: hold rst_n=0 with random inputs → out_valid=0, sum=0, cout=0, ovf=0, in_ready=0. After release → in_ready=1.
- Full skip chain: 0xFFFFFFFF+0x00000001, cin=0, sub=0 → sum=0x00000000, cout=1, ovf=0, out_valid exactly 2 cycles after accept.
- Signed overflow add: 0x7FFFFFFF+0x00000001 → sum=0x80000000, cout=0, ovf=1. Then 0x12345678+0x0FEDCBA9, cin=1 → 0x22222222, cout=0, ovf=0.
- Subtract: 5−7 (sub=1, cin=0) → 0xFFFFFFFE, cout=0, ovf=0. Then 0x80000000−1 → 0x7FFFFFFF, cout=1, ovf=1. Then 10−3 with cin=1 → 0x00000006, cout=1.
- Backpressure: issue 6 back-to-back ops; drop out_ready for 3 cycles after the first result.
  - in_ready must fall after 2 ops are buffered.
  - Outputs must hold stable while stalled.
  - All 6 results must arrive in order, none lost or repeated.
  - Throughput must be 1/cycle once out_ready returns.
- Reset mid-flight: assert rst_n=0 with 2 ops in flight → out_valid drops immediately. After release, no stale result appears; the next op returns the correct value with 2-cycle latency.

Source files
------------

// File: rtl/pipelined_cska.sv
`timescale 1ns/1ps
// pipelined_cska
//   Pipelined carry-skip adder/subtractor with valid/ready flow control.
//   Each of the STAGES register stages resolves a contiguous slice of
//   BLOCK-bit carry-skip blocks. Results stream out at one per cycle.
//
// Parameters
//   WIDTH   operand/result width, multiple of BLOCK*STAGES
//   BLOCK   bits per ripple block / skip group
//   STAGES  pipeline register stages, divides WIDTH/BLOCK
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake (in1, in2, cin, sub)
//   out_valid / out_ready result handshake (sum, cout, ovf)
//   sub=0: sum = in1 + in2 + cin
//   sub=1: sum = in1 - in2 - cin   (cout=1 means no borrow)
//   ovf: signed overflow (carry into MSB xor carry out of MSB)
module pipelined_cska #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned BLOCK  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NB = WIDTH / (BLOCK * STAGES); // blocks per stage
   localparam int unsigned SL = NB * BLOCK;               // bits per stage
   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Per-stage registers: resolved sum bits, operands, carry into the next
   // slice, carry into the MSB, valid.
   logic [WIDTH-1:0] a_q  [STAGES];
   logic [WIDTH-1:0] b_q  [STAGES];
   logic [WIDTH-1:0] s_q  [STAGES];
   logic             c_q  [STAGES];
   logic             cm_q [STAGES];
   logic             v_q  [STAGES];
   logic             rdy  [STAGES+1];

   // Holds in_ready low while reset is asserted and for the edge that
   // follows its release, so acceptance starts on a clean clock boundary.
   logic en_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) en_q <= 1'b0;
      else        en_q <= 1'b1;
   end

   assign rdy[STAGES] = out_ready;
   assign in_ready    = rdy[0] & en_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_in, b_in, s_in, s_d;
      logic             c_in, cm_in, v_in, c_d, cm_d;
      logic             bc, all_p, p, c_run;
      logic [IW-1:0]    bi;

      assign rdy[k] = !v_q[k] || rdy[k+1];

      if (k == 0) begin : g_head
         assign a_in  = in1;
         assign b_in  = sub ? ~in2 : in2;
         assign c_in  = cin ^ sub;
         assign s_in  = '0;
         assign cm_in = 1'b0;
         assign v_in  = in_valid & en_q;
      end else begin : g_body
         assign a_in  = a_q[k-1];
         assign b_in  = b_q[k-1];
         assign c_in  = c_q[k-1];
         assign s_in  = s_q[k-1];
         assign cm_in = cm_q[k-1];
         assign v_in  = v_q[k-1];
      end

      // Ripple inside each block; a block whose bits all propagate passes
      // its carry-in straight through instead of waiting for the ripple.
      always_comb begin
         s_d   = s_in;
         cm_d  = cm_in;
         c_run = c_in;
         bc    = 1'b0;
         all_p = 1'b0;
         p     = 1'b0;
         bi    = '0;
         for (int unsigned blk = 0; blk < NB; blk++) begin
            bc    = c_run;
            all_p = 1'b1;
            for (int unsigned i = 0; i < BLOCK; i++) begin
               bi       = IW'(k * SL + blk * BLOCK + i);
               p        = a_in[bi] ^ b_in[bi];
               all_p    = all_p & p;
               s_d[bi]  = p ^ bc;
               if (k == STAGES - 1 && blk == NB - 1 && i == BLOCK - 1)
                  cm_d = bc;
               bc       = (a_in[bi] & b_in[bi]) | (p & bc);
            end
            c_run = all_p ? c_run : bc;
         end
         c_d = c_run;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_q[k]  <= '0;
            b_q[k]  <= '0;
            s_q[k]  <= '0;
            c_q[k]  <= 1'b0;
            cm_q[k] <= 1'b0;
            v_q[k]  <= 1'b0;
         end else if (rdy[k]) begin
            v_q[k] <= v_in;
            if (v_in) begin
               a_q[k]  <= a_in;
               b_q[k]  <= b_in;
               s_q[k]  <= s_d;
               c_q[k]  <= c_d;
               cm_q[k] <= cm_d;
            end
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = cm_q[STAGES-1] ^ c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_cska.sv
`timescale 1ns/1ps
module tb_pipelined_cska;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, cin, sub;
   logic        out_valid, out_ready, cout, ovf;
   logic [31:0] in1, in2, sum;
   int          checks = 0;
   int          errs = 0;
   bit          done = 1'b0;

   always #5 clk = ~clk;

   pipelined_cska #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic        ov;
   } res_t;

   res_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference: plain unsigned and signed arithmetic.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic c, input logic s);
      res_t        r;
      logic [32:0] u;
      longint      sv, ci;
      ci = c;
      if (!s) begin
         u    = {1'b0, a} + {1'b0, b} + {32'd0, c};
         r.s  = u[31:0];
         r.co = u[32];
         sv   = longint'($signed(a)) + longint'($signed(b)) + ci;
      end else begin
         u    = {1'b0, a} - {1'b0, b} - {32'd0, c};
         r.s  = u[31:0];
         r.co = !u[32];
         sv   = longint'($signed(a)) - longint'($signed(b)) - ci;
      end
      r.ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      return r;
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input res_t e);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in1 = a; in2 = b; cin = c; sub = s;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (in_ready) exp_q.push_back(e);
      else begin
         checks++; errs++;
         $display("FAIL accept timeout: in_ready got 0, expected 1");
      end
   endtask

   task automatic issue_rand();
      logic [31:0] a, b;
      logic        c, s;
      a = $urandom; b = $urandom;
      c = 1'($urandom_range(1)); s = 1'($urandom_range(1));
      drive(a, b, c, s, model(a, b, c, s));
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0; in1 = $urandom; in2 = $urandom;
   endtask

   // Issue into an empty pipeline with out_ready=1 and measure latency.
   task automatic issue_lat(input string name, input logic [31:0] a,
                            input logic [31:0] b, input logic c,
                            input logic s, input logic [31:0] es,
                            input logic eco, input logic eov);
      int lat = 0;
      drive(a, b, c, s, {es, eco, eov});
      do begin
         @(negedge clk); in_valid = 1'b0; #1; lat++;
      end while (!out_valid && lat < 10);
      check({name, " latency"}, lat, 2);
   endtask

   // Monitor: pops the scoreboard on every output transfer and checks
   // that stalled outputs hold.
   initial begin : monitor
      res_t        e;
      logic        hold;
      logic [33:0] held;
      hold = 1'b0;
      held = '0;
      forever begin
         @(negedge clk); #1;
         if (!rst_n) hold = 1'b0;
         else begin
            if (hold)
               check("stall hold", {out_valid, sum, cout, ovf}, {1'b1, held});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; errs++;
                  $display("FAIL unexpected result: got sum=%h, expected none",
                           sum);
               end else begin
                  e = exp_q.pop_front();
                  check("result {sum,cout,ovf}", {sum, cout, ovf}, e);
               end
            end
            hold = out_valid && !out_ready;
            held = {sum, cout, ovf};
         end
      end
   end

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: got no finish, expected finish before 1ms");
      $fatal(1);
   end

   initial begin : main
      int n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;

      // Reset with random inputs toggling.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(1)); in1 = $urandom; in2 = $urandom;
         cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
         out_ready = 1'($urandom_range(1));
         #1;
         check("reset out_valid", out_valid, 0);
         check("reset sum", sum, 0);
         check("reset cout", cout, 0);
         check("reset ovf", ovf, 0);
         check("reset in_ready", in_ready, 0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #3 rst_n = 1'b1;
      @(negedge clk); #1;
      check("post-reset in_ready", in_ready, 1);
      check("post-reset out_valid", out_valid, 0);

      // Directed boundary cases.
      issue_lat("skip chain", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
                32'h0, 1'b1, 1'b0);
      issue_lat("ovf add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
                32'h8000_0000, 1'b0, 1'b1);
      issue_lat("add cin", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0,
                32'h2222_2222, 1'b0, 1'b0);
      issue_lat("sub 5-7", 32'd5, 32'd7, 1'b0, 1'b1,
                32'hFFFF_FFFE, 1'b0, 1'b0);
      issue_lat("sub min-1", 32'h8000_0000, 32'h1, 1'b0, 1'b1,
                32'h7FFF_FFFF, 1'b1, 1'b1);
      issue_lat("sub cin", 32'd10, 32'd3, 1'b1, 1'b1,
                32'd6, 1'b1, 1'b0);

      // Backpressure: 6 back-to-back ops, 3-cycle stall after first result.
      fork
         begin
            for (int i = 0; i < 6; i++) issue_rand();
            idle();
         end
         begin
            int m = 0;
            do begin
               @(negedge clk); #1; m++;
            end while (!out_valid && m < 20);
            check("bp first result", out_valid, 1);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk); out_ready = 1'b0; #1;
               check("bp in_ready stalled", in_ready, 0);
               check("bp out_valid stalled", out_valid, 1);
            end
            @(negedge clk); out_ready = 1'b1; #1;
            for (int i = 0; i < 5; i++) begin
               if (i > 0) begin @(negedge clk); #1; end
               check("bp throughput", out_valid, 1);
            end
         end
      join

      // Random traffic with random backpressure.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(3) == 0) idle();
               else issue_rand();
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               out_ready = ($urandom_range(3) != 0);
            end
         end
      join
      in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk); n++;
      end
      @(negedge clk); #2;
      check("drain pending", exp_q.size(), 0);

      // Reset with two operations in flight.
      out_ready = 1'b0;
      issue_rand();
      issue_rand();
      @(negedge clk); in_valid = 1'b0; #1;
      check("midflight pre-reset out_valid", out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      check("midflight out_valid", out_valid, 0);
      check("midflight sum", sum, 0);
      check("midflight in_ready", in_ready, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         check("no stale out_valid", out_valid, 0);
      end
      issue_lat("post-reset op", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0,
                32'h2222_2222, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #2;
      check("final pending", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
      $finish;
   end

endmodule
